// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite control-port initiator.
package axi_lite_pkg;

  // Transaction sequencing states of the initiator.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // AXI response encodings, reported untouched on rsp_resp.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Control registers are always written as full 32-bit words.
  localparam logic [3:0] STRB_ALL = 4'hF;

endpackage

// File: rtl/axi_lite_control_master_if.sv
// AXI4-Lite bus between the control initiator and a kernel's S_AXI_CONTROL port.
//
// Handshake rule on every channel: a transfer happens on the rising clock edge
// where VALID and READY are both high. The source raises VALID without waiting
// for READY, keeps it high with ADDR/DATA stable until that edge, and may drop
// it only afterwards. READY may be raised or lowered freely.
interface axi_lite_control_master_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
);

  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi_lite_control_master.sv
// Single-outstanding AXI4-Lite initiator: turns one cmd_* request into one
// AXI4-Lite read or write and returns a one-cycle rsp_valid pulse with the
// slave's data/response. Every output comes straight from a flop.
module axi_lite_control_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_resp,
  output state_t                    state_dbg,
  axi_lite_control_master_if.master m_axi_control
);

  state_t              state_q, state_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                arvalid_q, arvalid_d;
  logic                bready_q, bready_d;
  logic                rready_q, rready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = awvalid_q & m_axi_control.awready;
  assign w_hs  = wvalid_q  & m_axi_control.wready;
  assign b_hs  = bready_q  & m_axi_control.bvalid;
  assign ar_hs = arvalid_q & m_axi_control.arready;
  assign r_hs  = rready_q  & m_axi_control.rvalid;

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_write) begin
            awaddr_d = cmd_addr;
            wdata_d  = cmd_wdata;
            state_d  = ST_WR_REQ;
          end else begin
            araddr_d = cmd_addr;
            state_d  = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        // AW and W complete independently; the slave may take them in either order.
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (b_hs) begin
          rsp_resp_d  = m_axi_control.bresp;
          rsp_rdata_d = '0;
          state_d     = ST_DONE;
        end
      end
      ST_RD_REQ: begin
        if (ar_hs) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (r_hs) begin
          rsp_resp_d  = m_axi_control.rresp;
          rsp_rdata_d = m_axi_control.rdata;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs follow the state being entered, so they are flop outputs.
    awvalid_d   = (state_d == ST_WR_REQ) && !aw_done_d;
    wvalid_d    = (state_d == ST_WR_REQ) && !w_done_d;
    wstrb_d     = wvalid_d ? STRB_ALL : '0;
    arvalid_d   = (state_d == ST_RD_REQ);
    bready_d    = (state_d == ST_WR_RESP);
    rready_d    = (state_d == ST_RD_RESP);
    rsp_valid_d = (state_d == ST_DONE);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= ST_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wstrb_q     <= '0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wstrb_q     <= wstrb_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready             = cmd_ready_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_rdata             = rsp_rdata_q;
  assign rsp_resp              = rsp_resp_q;
  assign state_dbg             = state_q;
  assign m_axi_control.awvalid = awvalid_q;
  assign m_axi_control.awaddr  = awaddr_q;
  assign m_axi_control.wvalid  = wvalid_q;
  assign m_axi_control.wdata   = wdata_q;
  assign m_axi_control.wstrb   = wstrb_q;
  assign m_axi_control.bready  = bready_q;
  assign m_axi_control.arvalid = arvalid_q;
  assign m_axi_control.araddr  = araddr_q;
  assign m_axi_control.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_control_master.sv
// Bench for axi_lite_control_master: a word-addressed slave with programmable
// wait states, a register-file reference model predicting every response, and
// latency expectations derived from the slave's wait settings.
module tb_axi_lite_control_master;
  import axi_lite_pkg::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;

  // ---------------- clock / reset ----------------
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  initial forever #5 ap_clk = ~ap_clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr  = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  state_t            state_dbg;

  axi_lite_control_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_lite_control_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .state_dbg     (state_dbg),
    .m_axi_control (bus)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int last_rsp_cyc = 0;
  int rule_viol = 0;
  logic [33:0] exp_q[$];                 // {resp, rdata} per accepted command
  logic [31:0] ref_mem[logic [63:0]];    // reference register file
  logic [31:0] slave_mem[logic [63:0]];  // slave's own storage

  // slave configuration
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic [1:0] bresp_cfg, rresp_cfg;
  // slave state
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit got_aw, got_w, got_ar;
  logic bready_seen, rready_seen;
  logic [63:0] aw_obs, ar_obs;
  logic [31:0] w_obs;
  logic [3:0]  strb_obs;
  // monitor history
  logic p_awvalid, p_wvalid, p_arvalid;
  logic [63:0] p_awaddr, p_araddr;
  logic [31:0] p_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] unwritten_value(input logic [63:0] a);
    return ~a[31:0];
  endfunction

  // ---------------- slave model ----------------
  task automatic slave_reset();
    bus.awready = 0; bus.wready = 0; bus.arready = 0;
    bus.bvalid = 0; bus.rvalid = 0; bus.bresp = 0; bus.rresp = 0; bus.rdata = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    got_aw = 0; got_w = 0; got_ar = 0;
    bready_seen = 0; rready_seen = 0;
  endtask

  task automatic slave_eval();
    if (ap_rst) begin
      slave_reset();
      return;
    end
    // handshakes that completed on the edge just passed
    if (bus.awready) begin bus.awready = 0; got_aw = 1; end
    if (bus.wready)  begin bus.wready = 0;  got_w = 1;  end
    if (bus.arready) begin bus.arready = 0; got_ar = 1; end
    if (bus.bvalid && bready_seen) begin bus.bvalid = 0; got_aw = 0; got_w = 0; b_cnt = 0; end
    if (bus.rvalid && rready_seen) begin bus.rvalid = 0; got_ar = 0; r_cnt = 0; end
    // drive this cycle
    if (bus.awvalid && !got_aw) begin
      if (aw_cnt >= aw_wait) begin bus.awready = 1; aw_obs = bus.awaddr; aw_cnt = 0; end
      else aw_cnt++;
    end
    if (bus.wvalid && !got_w) begin
      if (w_cnt >= w_wait) begin bus.wready = 1; w_obs = bus.wdata; strb_obs = bus.wstrb; w_cnt = 0; end
      else w_cnt++;
    end
    if (got_aw && got_w && !bus.bvalid) begin
      if (b_cnt >= b_wait) begin
        bus.bvalid = 1; bus.bresp = bresp_cfg; slave_mem[aw_obs] = w_obs;
      end else b_cnt++;
    end
    if (bus.arvalid && !got_ar) begin
      if (ar_cnt >= ar_wait) begin bus.arready = 1; ar_obs = bus.araddr; ar_cnt = 0; end
      else ar_cnt++;
    end
    if (got_ar && !bus.rvalid) begin
      if (r_cnt >= r_wait) begin
        bus.rvalid = 1; bus.rresp = rresp_cfg;
        bus.rdata = slave_mem.exists(ar_obs) ? slave_mem[ar_obs] : unwritten_value(ar_obs);
      end else r_cnt++;
    end
    bready_seen = bus.bready;
    rready_seen = bus.rready;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor();
    logic [33:0] e;
    if (!ap_rst) begin
      if (p_awvalid && !bus.awready && (!bus.awvalid || bus.awaddr !== p_awaddr)) rule_viol++;
      if (p_wvalid && !bus.wready && (!bus.wvalid || bus.wdata !== p_wdata)) rule_viol++;
      if (p_arvalid && !bus.arready && (!bus.arvalid || bus.araddr !== p_araddr)) rule_viol++;
    end
    if (bus.wstrb !== (bus.wvalid ? 4'hF : 4'h0)) rule_viol++;
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
      check("ready_at_rsp", cmd_ready, 0);
      check("rsp_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e[31:0]);
        check("rsp_resp", rsp_resp, e[33:32]);
      end
    end
    p_awvalid = bus.awvalid; p_wvalid = bus.wvalid; p_arvalid = bus.arvalid;
    p_awaddr = bus.awaddr; p_araddr = bus.araddr; p_wdata = bus.wdata;
  endtask

  // one clock: everything is sampled and driven on the falling edge
  task automatic step();
    @(negedge ap_clk);
    cyc++;
    monitor();
    slave_eval();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input int aw, input int w, input int b, input int ar, input int r,
                         input logic [1:0] br, input logic [1:0] rr);
    aw_wait = aw; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
    bresp_cfg = br; rresp_cfg = rr;
  endtask

  task automatic predict(input bit wr, input logic [63:0] a, input logic [31:0] d);
    if (wr) begin
      ref_mem[a] = d;
      exp_q.push_back({bresp_cfg, 32'h0});
    end else begin
      exp_q.push_back({rresp_cfg, ref_mem.exists(a) ? ref_mem[a] : unwritten_value(a)});
    end
  endtask

  // presents a command until accepted; returns at the cycle after acceptance
  task automatic start_cmd(input bit wr, input logic [63:0] a, input logic [31:0] d, output int acc);
    int n = 0;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1;
    while (!cmd_ready && n < 50) begin step(); n++; end
    check("cmd_ready_wait", cmd_ready, 1);
    if (!cmd_ready) begin cmd_valid = 0; acc = -1; return; end
    acc = cyc;
    predict(wr, a, d);
    step();
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int bound, output int rc);
    int start = rsp_cnt;
    int n = 0;
    while (rsp_cnt == start && n < bound) begin step(); n++; end
    check("rsp_arrived", rsp_cnt - start, 1);
    rc = last_rsp_cyc;
  endtask

  task automatic finish_cmd(input bit wr, input logic [63:0] a, input logic [31:0] d, input int acc);
    int rc;
    int lat;
    lat = wr ? 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait : 3 + ar_wait + r_wait;
    wait_rsp(60, rc);
    check("latency", rc - acc, lat);
    if (wr) begin
      check("awaddr_seen", aw_obs, a);
      check("wdata_seen", w_obs, d);
      check("wstrb_seen", strb_obs, 4'hF);
    end else begin
      check("araddr_seen", ar_obs, a);
    end
    step();
    check("single_pulse", rsp_valid, 0);
    check("ready_after_rsp", cmd_ready, 1);
  endtask

  task automatic do_cmd(input bit wr, input logic [63:0] a, input logic [31:0] d);
    int acc;
    start_cmd(wr, a, d, acc);
    if (acc >= 0) finish_cmd(wr, a, d, acc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int n;
    int idx;
    int start;
    int acc_a[3];
    bit          st_wr[3];
    logic [63:0] st_a[3];
    logic [31:0] st_d[3];
    logic [63:0] a;

    slave_reset();
    set_cfg(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY);
    p_awvalid = 0; p_wvalid = 0; p_arvalid = 0;
    p_awaddr = 0; p_araddr = 0; p_wdata = 0;
    ref_mem[64'h18] = 32'h1;
    slave_mem[64'h18] = 32'h1;

    // reset values
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    check("rst_addr_data", {bus.awaddr, bus.araddr, bus.wdata, bus.wstrb}, 0);
    check("rst_rsp", {rsp_valid, rsp_rdata, rsp_resp}, 0);
    check("rst_state", state_dbg, ST_IDLE);
    ap_rst = 0;
    step();
    check("ready_after_rst", cmd_ready, 1);

    // zero-wait write with cycle-by-cycle channel checks
    start_cmd(1, 64'h10, 32'hDEADBEEF, acc);
    check("zw_awvalid_c1", {bus.awvalid, bus.wvalid}, 2'b11);
    check("zw_awaddr_c1", bus.awaddr, 64'h10);
    check("zw_wdata_c1", bus.wdata, 32'hDEADBEEF);
    check("zw_wstrb_c1", bus.wstrb, 4'hF);
    step();
    check("zw_bready_c2", bus.bready, 1);
    check("zw_valids_c2", {bus.awvalid, bus.wvalid, bus.wstrb}, 0);
    finish_cmd(1, 64'h10, 32'hDEADBEEF, acc);

    // zero-wait read
    start_cmd(0, 64'h10, 32'h0, acc);
    check("zr_arvalid_c1", bus.arvalid, 1);
    check("zr_araddr_c1", bus.araddr, 64'h10);
    step();
    check("zr_rready_c2", {bus.rready, bus.arvalid}, 2'b10);
    finish_cmd(0, 64'h10, 32'h0, acc);

    // split write handshake: AW taken in cycle 1, W in cycle 4
    set_cfg(0, 3, 0, 0, 0, RESP_OKAY, RESP_OKAY);
    start_cmd(1, 64'h24, 32'h0BADF00D, acc);
    check("split_c1", {bus.awvalid, bus.wvalid}, 2'b11);
    step();
    check("split_c2", {bus.awvalid, bus.wvalid}, 2'b01);
    step();
    check("split_c3", {bus.awvalid, bus.wvalid}, 2'b01);
    step();
    check("split_c4", {bus.awvalid, bus.wvalid, bus.bready}, 3'b010);
    finish_cmd(1, 64'h24, 32'h0BADF00D, acc);

    // delayed read of a preloaded register
    set_cfg(0, 0, 0, 2, 3, RESP_OKAY, RESP_OKAY);
    do_cmd(0, 64'h18, 32'h0);

    // error write, then a normal read of the same register
    set_cfg(0, 0, 0, 0, 0, RESP_SLVERR, RESP_OKAY);
    do_cmd(1, 64'h20, 32'h12345678);
    set_cfg(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY);
    do_cmd(0, 64'h20, 32'h0);

    // unaligned address passes through
    do_cmd(1, 64'h23, 32'hA5A5_0001);
    do_cmd(0, 64'h23, 32'h0);

    // back-to-back stream with cmd_valid held high throughout
    st_wr = '{1'b1, 1'b0, 1'b0};
    st_a  = '{64'h00, 64'h00, 64'h10};
    st_d  = '{32'h1, 32'h0, 32'h0};
    idx = 0; n = 0; start = rsp_cnt;
    cmd_write = st_wr[0]; cmd_addr = st_a[0]; cmd_wdata = st_d[0]; cmd_valid = 1;
    while ((idx < 3 || rsp_cnt - start < 3) && n < 80) begin
      if (idx < 3 && cmd_ready) begin
        acc_a[idx] = cyc;
        predict(st_wr[idx], st_a[idx], st_d[idx]);
        idx++;
        step();
        if (idx < 3) begin
          cmd_write = st_wr[idx]; cmd_addr = st_a[idx]; cmd_wdata = st_d[idx];
        end else cmd_valid = 0;
      end else step();
      n++;
    end
    cmd_valid = 0;
    check("stream_rsps", rsp_cnt - start, 3);
    check("stream_gap1", acc_a[1] - acc_a[0], 4);
    check("stream_gap2", acc_a[2] - acc_a[1], 4);
    step();

    // reset during WR_RESP
    set_cfg(0, 0, 30, 0, 0, RESP_OKAY, RESP_OKAY);
    start_cmd(1, 64'h200, 32'hCAFE_0200, acc);
    step();
    check("abort_in_wr_resp", bus.bready, 1);
    ap_rst = 1;
    slave_reset();
    exp_q.delete();
    start = rsp_cnt;
    step();
    check("abort_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    check("abort_ready_in_rst", cmd_ready, 0);
    check("abort_state", state_dbg, ST_IDLE);
    ap_rst = 0;
    step();
    check("abort_ready_after", cmd_ready, 1);
    repeat (5) step();
    check("abort_no_rsp", rsp_cnt - start, 0);

    // randomized commands against the reference register file
    for (int i = 0; i < 40; i++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY,
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY);
      a = 64'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 64'($urandom_range(1, 3));
      do_cmd(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) step();
    end

    check("axi_rules", rule_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
